// File: rtl/regfile_mp_pkg.sv
// Shared types for the multi-port integer register file: ABI register names,
// register-count constants, sequencer states and the ABI init addresses.
package regfile_mp_pkg;

    localparam int NREGS_RV32I = 32;
    localparam int NREGS_RV32E = 16;

    localparam logic [31:0] DATA_ORG = 32'h0000_0500;
    localparam logic [31:0] DATA_END = 32'h0000_0900;

    typedef enum logic [4:0] {
        REG_ZERO, REG_RA, REG_SP, REG_GP, REG_TP, REG_T0, REG_T1, REG_T2,
        REG_S0, REG_S1, REG_A0, REG_A1, REG_A2, REG_A3, REG_A4, REG_A5,
        REG_A6, REG_A7, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
        REG_S8, REG_S9, REG_S10, REG_S11, REG_T3, REG_T4, REG_T5, REG_T6
    } reg_e;

    typedef enum logic [1:0] {
        RF_RESET,
        RF_CLEAR,
        RF_READY
    } regfile_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: decode-side read ports plus the writeback write port.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREAD = 2
);
    import regfile_mp_pkg::*;

    // Reads and writes are unconditional per cycle (no handshake); the only
    // flow control is busy, on which upstream must stall its writes.
    reg_e             rd_addr [NREAD];
    logic [XLEN-1:0]  rd_data [NREAD];
    logic             we;
    reg_e             wr_addr;
    logic [XLEN-1:0]  wr_data;
    logic             busy;
    logic             addr_err;

    modport master (
        output rd_addr, we, wr_addr, wr_data,
        input  rd_data, busy, addr_err
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data,
        output rd_data, busy, addr_err
    );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port: x0/range/busy masking and write-to-read bypass.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            busy_i,
    input  reg_e            rd_addr_i,
    input  logic [XLEN-1:0] arr_data_i,
    input  logic            we_i,
    input  reg_e            wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic            oor_o
);

    logic [4:0] addr;
    logic       hit;

    assign addr  = rd_addr_i;
    assign oor_o = {1'b0, addr} >= 6'(NREGS);
    // A matching write is necessarily legal here because the read side
    // already filters zero and out-of-range addresses.
    assign hit   = (BYPASS != 0) && we_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o = '0;
        if (!busy_i && !oor_o && rd_addr_i != REG_ZERO) begin
            rd_data_o = hit ? wr_data_i : arr_data_i;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a post-reset clear sequencer
// that zeroes the array and loads ABI defaults into sp and gp.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int              NREGS   = 32,
    parameter int              NREAD   = 2,
    parameter int              BYPASS  = 1,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(DATA_END),
    parameter logic [XLEN-1:0] GP_INIT = XLEN'(DATA_ORG)
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_if.slave    rf,
    output regfile_state_e state_o
);

    localparam int AW = $clog2(NREGS);

    if (NREGS != NREGS_RV32I && NREGS != NREGS_RV32E) begin : g_bad_nregs
        $error("regfile_mp: NREGS must be 16 or 32");
    end
    if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
        $error("regfile_mp: NREAD must be 1..4");
    end

    logic [XLEN-1:0] regs_q [NREGS];
    regfile_state_e  state_q;
    logic [AW-1:0]   cnt_q;
    logic            busy_q;
    logic            addr_err_q;
    logic            addr_err_d;

    logic [NREAD-1:0] rd_oor;
    logic [4:0]       wa;
    logic             wr_oor;
    logic             wr_legal;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [XLEN-1:0]  mem_wdata;

    assign wa         = rf.wr_addr;
    assign wr_oor     = rf.we && ({1'b0, wa} >= 6'(NREGS));
    assign wr_legal   = rf.we && !wr_oor && (rf.wr_addr != REG_ZERO);
    assign addr_err_d = (state_q == RF_READY) && (wr_oor || (|rd_oor));

    // Single array write port shared by the clear walk and normal writeback.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        case (state_q)
            RF_CLEAR: begin
                mem_we = 1'b1;
                if (cnt_q == AW'(REG_SP)) mem_wdata = SP_INIT;
                else if (cnt_q == AW'(REG_GP)) mem_wdata = GP_INIT;
            end
            RF_READY: begin
                mem_we    = wr_legal;
                mem_addr  = AW'(rf.wr_addr);
                mem_wdata = rf.wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) regs_q[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RF_RESET;
            cnt_q      <= AW'(1);
            busy_q     <= 1'b1;
            addr_err_q <= 1'b0;
        end else begin
            case (state_q)
                RF_RESET: begin
                    state_q    <= RF_CLEAR;
                    cnt_q      <= AW'(1);
                    busy_q     <= 1'b1;
                    addr_err_q <= 1'b0;
                end
                RF_CLEAR: begin
                    addr_err_q <= 1'b0;
                    if (cnt_q == AW'(NREGS - 1)) begin
                        state_q <= RF_READY;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RF_READY: addr_err_q <= addr_err_d;
                default: begin
                    state_q <= RF_RESET;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        regfile_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .BYPASS(BYPASS)
        ) u_port (
            .busy_i    (busy_q),
            .rd_addr_i (rf.rd_addr[i]),
            .arr_data_i(regs_q[AW'(rf.rd_addr[i])]),
            .we_i      (rf.we),
            .wr_addr_i (rf.wr_addr),
            .wr_data_i (rf.wr_data),
            .rd_data_o (rf.rd_data[i]),
            .oor_o     (rd_oor[i])
        );
    end

    assign rf.busy     = busy_q;
    assign rf.addr_err = addr_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: RV32I with bypass (a), RV32I without bypass (b)
// and RV32E with bypass (e), sharing clock and reset.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREAD(2)) if_a ();
    regfile_mp_if #(.XLEN(32), .NREAD(2)) if_b ();
    regfile_mp_if #(.XLEN(32), .NREAD(2)) if_e ();
    regfile_state_e st_a, st_b, st_e;

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rf(if_a), .state_o(st_a));
    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rf(if_b), .state_o(st_b));
    regfile_mp #(.XLEN(32), .NREGS(16), .NREAD(2), .BYPASS(1)) dut_e (
        .clk(clk), .rst(rst), .rf(if_e), .state_o(st_e));

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eerr;
    } vec_t;

    vec_t vecs_a[10];
    vec_t vecs_b[3];
    vec_t vecs_e[8];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1);
        case (which)
            0: begin
                if_a.we = we; if_a.wr_addr = reg_e'(wa); if_a.wr_data = wd;
                if_a.rd_addr[0] = reg_e'(r0); if_a.rd_addr[1] = reg_e'(r1);
            end
            1: begin
                if_b.we = we; if_b.wr_addr = reg_e'(wa); if_b.wr_data = wd;
                if_b.rd_addr[0] = reg_e'(r0); if_b.rd_addr[1] = reg_e'(r1);
            end
            default: begin
                if_e.we = we; if_e.wr_addr = reg_e'(wa); if_e.wr_data = wd;
                if_e.rd_addr[0] = reg_e'(r0); if_e.rd_addr[1] = reg_e'(r1);
            end
        endcase
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply one vector for a cycle, check mid-cycle, leave the DUT idle afterwards.
    task automatic run_vec(input int which, input vec_t v, input string tag);
        logic [31:0] d0, d1;
        logic        err;
        drive(which, v.we, v.wa, v.wd, v.r0, v.r1);
        @(negedge clk);
        case (which)
            0:       begin d0 = if_a.rd_data[0]; d1 = if_a.rd_data[1]; err = if_a.addr_err; end
            1:       begin d0 = if_b.rd_data[0]; d1 = if_b.rd_data[1]; err = if_b.addr_err; end
            default: begin d0 = if_e.rd_data[0]; d1 = if_e.rd_data[1]; err = if_e.addr_err; end
        endcase
        check({tag, ".rd0"}, d0, v.e0);
        check({tag, ".rd1"}, d1, v.e1);
        check({tag, ".addr_err"}, 32'(err), 32'(v.eerr));
        next_cycle();
        drive(which, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    // Counts busy cycles from the current point (just after rst release) and
    // drops each DUT's write enable the moment it leaves busy.
    task automatic wait_clear(input string tag);
        int  ca = 0, cb = 0, ce = 0, guard = 0;
        bit  mask_bad = 1'b0;
        while ((if_a.busy || if_b.busy || if_e.busy) && guard < 200) begin
            if (if_a.busy) begin
                ca++;
                if (if_a.rd_data[0] !== 32'd0 || if_a.rd_data[1] !== 32'd0) mask_bad = 1'b1;
            end else if_a.we = 1'b0;
            if (if_b.busy) begin
                cb++;
                if (if_b.rd_data[0] !== 32'd0 || if_b.rd_data[1] !== 32'd0) mask_bad = 1'b1;
            end else if_b.we = 1'b0;
            if (if_e.busy) begin
                ce++;
                if (if_e.rd_data[0] !== 32'd0 || if_e.rd_data[1] !== 32'd0) mask_bad = 1'b1;
            end else if_e.we = 1'b0;
            guard++;
            next_cycle();
        end
        if_a.we = 1'b0; if_b.we = 1'b0; if_e.we = 1'b0;
        check({tag, ".timeout"}, 32'(guard >= 200), 32'd0);
        check({tag, ".busy_cycles_a"}, 32'(ca), 32'd32);
        check({tag, ".busy_cycles_b"}, 32'(cb), 32'd32);
        check({tag, ".busy_cycles_e"}, 32'(ce), 32'd16);
        check({tag, ".busy_read_mask"}, 32'(mask_bad), 32'd0);
    endtask

    initial begin
        //             we    wa     wd            r0     r1     e0            e1            err
        vecs_a[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs_a[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd2,  32'hDEADBEEF, 32'h900,      1'b0};
        vecs_a[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs_a[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs_a[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs_a[5] = '{1'b1, 5'd30, 32'h11112222, 5'd31, 5'd30, 32'hCAFEF00D, 32'h11112222, 1'b0};
        vecs_a[6] = '{1'b1, 5'd2,  32'h1000,     5'd2,  5'd3,  32'h1000,     32'h500,      1'b0};
        vecs_a[7] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd30, 32'h1000,     32'h11112222, 1'b0};
        vecs_a[8] = '{1'b1, 5'd20, 32'hAA,       5'd20, 5'd0,  32'hAA,       32'h0,        1'b0};
        vecs_a[9] = '{1'b0, 5'd0,  32'h0,        5'd20, 5'd20, 32'hAA,       32'hAA,       1'b0};

        vecs_b[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0,        32'h0,        1'b0};
        vecs_b[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs_b[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};

        vecs_e[0] = '{1'b1, 5'd1,  32'h77,       5'd1,  5'd0,  32'h77,       32'h0,        1'b0};
        vecs_e[1] = '{1'b1, 5'd20, 32'hAA,       5'd4,  5'd1,  32'h0,        32'h77,       1'b0};
        vecs_e[2] = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd1,  32'h0,        32'h77,       1'b1};
        vecs_e[3] = '{1'b0, 5'd0,  32'h0,        5'd17, 5'd1,  32'h0,        32'h77,       1'b0};
        vecs_e[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b1};
        vecs_e[5] = '{1'b1, 5'd16, 32'hBB,       5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs_e[6] = '{1'b1, 5'd15, 32'h15,       5'd15, 5'd0,  32'h15,       32'h0,        1'b1};
        vecs_e[7] = '{1'b0, 5'd0,  32'h0,        5'd15, 5'd0,  32'h15,       32'h0,        1'b0};

        // Reset: two edges with rst high, reads pointed at sp/gp must stay 0.
        rst = 1'b1;
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 5'd0, 32'd0, 5'd2, 5'd3);
        @(posedge clk);
        @(negedge clk);
        check("reset.busy_a", 32'(if_a.busy), 32'd1);
        check("reset.busy_e", 32'(if_e.busy), 32'd1);
        check("reset.addr_err_a", 32'(if_a.addr_err), 32'd0);
        check("reset.addr_err_e", 32'(if_e.addr_err), 32'd0);
        check("reset.rd0_a", if_a.rd_data[0], 32'd0);
        check("reset.rd1_e", if_e.rd_data[1], 32'd0);
        next_cycle();

        // Release reset while a write to x7 is held during the whole clear.
        rst = 1'b0;
        for (int w = 0; w < 3; w++) drive(w, 1'b1, 5'd7, 32'h55, 5'd2, 5'd3);
        wait_clear("clear1");
        check("ready.state_a", 32'(st_a), 32'(RF_READY));
        check("ready.state_e", 32'(st_e), 32'(RF_READY));

        for (int w = 0; w < 3; w++) drive(w, 1'b0, 5'd0, 32'd0, 5'd2, 5'd3);
        @(negedge clk);
        check("init.sp_a", if_a.rd_data[0], 32'h900);
        check("init.gp_a", if_a.rd_data[1], 32'h500);
        check("init.sp_b", if_b.rd_data[0], 32'h900);
        check("init.sp_e", if_e.rd_data[0], 32'h900);
        check("init.gp_e", if_e.rd_data[1], 32'h500);
        next_cycle();
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7);
        @(negedge clk);
        check("init.x5_a", if_a.rd_data[0], 32'd0);
        check("busy_wr.x7_a", if_a.rd_data[1], 32'd0);
        check("busy_wr.x7_b", if_b.rd_data[1], 32'd0);
        check("busy_wr.x7_e", if_e.rd_data[1], 32'd0);
        next_cycle();
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        for (int i = 0; i < 10; i++) run_vec(0, vecs_a[i], $sformatf("a[%0d]", i));
        for (int i = 0; i < 3; i++)  run_vec(1, vecs_b[i], $sformatf("b[%0d]", i));
        for (int i = 0; i < 8; i++)  run_vec(2, vecs_e[i], $sformatf("e[%0d]", i));

        // Reset mid-clear: re-assert rst after ten clear steps.
        begin
            bit dropped = 1'b0;
            rst = 1'b1;
            for (int w = 0; w < 3; w++) drive(w, 1'b0, 5'd0, 32'd0, 5'd5, 5'd1);
            next_cycle();
            rst = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (!if_a.busy || !if_e.busy) dropped = 1'b1;
                next_cycle();
            end
            rst = 1'b1;
            next_cycle();
            if (!if_a.busy || !if_e.busy) dropped = 1'b1;
            rst = 1'b0;
            check("midclear.busy_held", 32'(dropped), 32'd0);
            wait_clear("clear2");
        end
        @(negedge clk);
        check("reclear.x5_a", if_a.rd_data[0], 32'd0);
        check("reclear.x5_b", if_b.rd_data[0], 32'd0);
        check("reclear.x1_e", if_e.rd_data[1], 32'd0);
        next_cycle();
        drive(0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd30);
        @(negedge clk);
        check("reclear.sp_a", if_a.rd_data[0], 32'h900);
        check("reclear.x30_a", if_a.rd_data[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
